// File: rtl/m6809_busclk_pkg.sv
// Shared types and width helpers for the 6809 E/Q bus clock generator.
package m6809_busclk_pkg;

  typedef enum logic [1:0] {PH0, PH1, PH2, PH3} phase_t;

  // Width of a counter that must hold values 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int tick_w(input int qtr_div);
    return cnt_w(qtr_div);
  endfunction

  function automatic int stretch_w(input int max_stretch);
    return cnt_w(max_stretch + 1);
  endfunction

  function automatic int deb_w(input int debounce);
    return cnt_w(debounce);
  endfunction

  function automatic int hold_w(input int rst_hold);
    return cnt_w(rst_hold + 1);
  endfunction

  // E is high in the second half of the cycle, Q in the middle half.
  function automatic logic phase_e(input phase_t ph);
    return (ph == PH2) || (ph == PH3);
  endfunction

  function automatic logic phase_q(input phase_t ph);
    return (ph == PH1) || (ph == PH2);
  endfunction

endpackage

// File: rtl/m6809_btn_debounce.sv
// Reset button conditioner: 2-flop synchroniser followed by a consecutive-sample
// debounce filter. level is the accepted (active-low) button level.
module m6809_btn_debounce
  import m6809_busclk_pkg::*;
#(
  parameter int DEBOUNCE = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic level
);

  localparam int DW = deb_w(DEBOUNCE);
  localparam logic [DW-1:0] CNT_LAST = DW'(DEBOUNCE - 1);

  logic          sync1;
  logic          sync2;
  logic [DW-1:0] cnt;

  // Resetting to "pressed" keeps the CPU in reset until a release is proven.
  always_ff @(posedge clk) begin
    // NOTE: clocked state always uses non-blocking (<=) so every flop samples pre-edge values.
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
      if (sync2 != level) begin
        if (cnt == CNT_LAST) begin
          level <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/m6809_busclk_gen.sv
// 6809 quadrature E/Q clock generator with MRDY stretching and a stretched CPU reset.
// Optional single-step control is enabled by defining M6809_CLK_STEP_EN.
module m6809_busclk_gen
  import m6809_busclk_pkg::*;
#(
  parameter int QTR_DIV     = 4,
  parameter int MAX_STRETCH = 10,
  parameter int DEBOUNCE    = 8,
  parameter int RST_HOLD    = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic mrdy,
  input  logic rst_btn_n,
  output logic e,
  output logic q,
  output logic e_rise,
  output logic e_fall,
  output logic stretching,
  output logic reset_b
`ifdef M6809_CLK_STEP_EN
  ,
  input  logic run,
  input  logic step
`endif
);

  localparam int TW = tick_w(QTR_DIV);
  localparam int SW = stretch_w(MAX_STRETCH);
  localparam int HW = hold_w(RST_HOLD);
  localparam logic [TW-1:0] TICK_LAST   = TW'(QTR_DIV - 1);
  localparam logic [SW-1:0] STRETCH_MAX = SW'(MAX_STRETCH);
  localparam logic [HW-1:0] HOLD_LAST   = HW'(RST_HOLD - 1);

  logic [TW-1:0] tick;
  logic [SW-1:0] stretch_cnt;
  logic [HW-1:0] hold_cnt;
  phase_t        phase;
  phase_t        phase_nxt;
  logic          quarter_end;
  logic          stretch_go;
  logic          advance;
  logic          btn_level;

  m6809_btn_debounce #(
    .DEBOUNCE(DEBOUNCE)
  ) u_btn (
    .clk  (clk),
    .rst  (rst),
    .btn_n(rst_btn_n),
    .level(btn_level)
  );

`ifdef M6809_CLK_STEP_EN
  // Parked means sitting at the very start of P0; a step lets exactly that clk advance.
  logic parked;
  assign parked  = !run && (phase == PH0) && (tick == '0);
  assign advance = !parked || step;
`else
  assign advance = 1'b1;
`endif

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    phase_nxt   = phase;
    quarter_end = (tick == TICK_LAST);
    stretch_go  = !mrdy && (stretch_cnt < STRETCH_MAX);
    case (phase)
      PH0: phase_nxt = PH1;
      PH1: phase_nxt = PH2;
      PH2: phase_nxt = PH3;
      PH3: phase_nxt = stretch_go ? PH3 : PH0;
      default: phase_nxt = PH0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick        <= '0;
      phase       <= PH0;
      stretch_cnt <= '0;
      e           <= 1'b0;
      q           <= 1'b0;
      e_rise      <= 1'b0;
      e_fall      <= 1'b0;
      stretching  <= 1'b0;
    end else begin
      e_rise <= 1'b0;
      e_fall <= 1'b0;
      if (advance) begin
        if (quarter_end) begin
          tick   <= '0;
          phase  <= phase_nxt;
          e      <= phase_e(phase_nxt);
          q      <= phase_q(phase_nxt);
          e_rise <= (phase == PH1);
          if (phase == PH3) begin
            stretching  <= stretch_go;
            stretch_cnt <= stretch_go ? stretch_cnt + 1'b1 : '0;
            e_fall      <= !stretch_go;
          end
        end else begin
          tick <= tick + 1'b1;
        end
      end
    end
  end

  // Hold counts completed E-cycles; parking stops e_fall, so the hold pauses with it.
  always_ff @(posedge clk) begin
    if (rst || !btn_level) begin
      reset_b  <= 1'b0;
      hold_cnt <= '0;
    end else if (!reset_b && e_fall) begin
      hold_cnt <= hold_cnt + 1'b1;
      if (hold_cnt == HOLD_LAST) reset_b <= 1'b1;
    end
  end

endmodule

// File: tb/tb_m6809_busclk_gen.sv
// Randomised bench for m6809_busclk_gen against a cycle-position reference model.
module tb_m6809_busclk_gen;

  localparam int QTR_DIV     = 4;
  localparam int MAX_STRETCH = 10;
  localparam int DEBOUNCE    = 8;
  localparam int RST_HOLD    = 16;

  logic clk = 1'b0;
  logic rst, mrdy, rst_btn_n, run, step;
  logic e, q, e_rise, e_fall, stretching, reset_b;

  always #5 clk = ~clk;

  m6809_busclk_gen #(
    .QTR_DIV    (QTR_DIV),
    .MAX_STRETCH(MAX_STRETCH),
    .DEBOUNCE   (DEBOUNCE),
    .RST_HOLD   (RST_HOLD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mrdy      (mrdy),
    .rst_btn_n (rst_btn_n),
    .e         (e),
    .q         (q),
    .e_rise    (e_rise),
    .e_fall    (e_fall),
    .stretching(stretching),
    .reset_b   (reset_b)
`ifdef M6809_CLK_STEP_EN
    ,
    .run       (run),
    .step      (step)
`endif
  );

  int n_vec;
  int n_miscmp;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the clock is described by the position of the current clk
  // inside its E-cycle (cycle base + planned stretch length), the button by its
  // synchroniser delay and run length of differing samples, the reset by e_fall count.
  int m_cnt, m_base, m_z, m_k, m_run_len, m_hold;
  bit m_moved, m_s1, m_s2, m_acc, m_rb;
  bit drv_rst, drv_btn, drv_run, drv_step;

  function automatic void new_plan();
    m_z = $urandom_range(0, MAX_STRETCH + 2);
    m_k = (m_z > MAX_STRETCH) ? MAX_STRETCH : m_z;
  endfunction

  // Expected {e, q, e_rise, e_fall, stretching, reset_b} for the current state.
  function automatic logic [5:0] expected();
    int p;
    logic [5:0] r;
    p    = m_cnt - m_base;
    r[5] = (p >= 2 * QTR_DIV);
    r[4] = (p >= QTR_DIV) && (p < 3 * QTR_DIV);
    r[3] = m_moved && (p == 2 * QTR_DIV);
    r[2] = m_moved && (p == 0) && (m_base > 0);
    r[1] = (p >= 4 * QTR_DIV);
    r[0] = m_rb;
    return r;
  endfunction

  // mrdy for the next edge: planned at P3 quarter ends, random noise elsewhere.
  function automatic logic pick_mrdy();
    int np;
    np = m_cnt - m_base + 1;
    if (np >= 4 * QTR_DIV && (np - 4 * QTR_DIV) % QTR_DIV == 0)
      return ((np - 4 * QTR_DIV) / QTR_DIV < m_z) ? 1'b0 : 1'b1;
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic void model_step(input bit r, input bit b, input bit rn, input bit st);
    logic [5:0] ev;
    if (r) begin
      m_cnt = 0; m_base = 0; m_moved = 0;
      m_s1 = 0; m_s2 = 0; m_acc = 0; m_run_len = 0;
      m_rb = 0; m_hold = 0;
      new_plan();
      return;
    end
    ev = expected();
    if (!m_acc) begin
      m_rb = 0;
      m_hold = 0;
    end else if (!m_rb && ev[2]) begin
      m_hold++;
      if (m_hold == RST_HOLD) m_rb = 1;
    end
    if (m_s2 != m_acc) begin
      m_run_len++;
      if (m_run_len == DEBOUNCE) begin
        m_acc = m_s2;
        m_run_len = 0;
      end
    end else begin
      m_run_len = 0;
    end
    m_s2 = m_s1;
    m_s1 = b;
    if (!rn && (m_cnt == m_base) && !st) begin
      m_moved = 0;
    end else begin
      m_cnt++;
      m_moved = 1;
      if (m_cnt - m_base == 4 * QTR_DIV + QTR_DIV * m_k) begin
        m_base = m_cnt;
        new_plan();
      end
    end
  endfunction

  // One clk: compare current outputs, drive next inputs, advance model and DUT.
  task automatic tick(input string tag);
    logic [5:0] exp_v;
    exp_v = expected();
    check(tag, {10'd0, e, q, e_rise, e_fall, stretching, reset_b}, {10'd0, exp_v});
    mrdy      = pick_mrdy();
    rst       = drv_rst;
    rst_btn_n = drv_btn;
    run       = drv_run;
    step      = drv_step;
    model_step(drv_rst, drv_btn, drv_run, drv_step);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int guard;
    int rises;
    int falls;
    n_vec = 0;
    n_miscmp = 0;
    drv_rst = 1; drv_btn = 1; drv_run = 1; drv_step = 0;
    rst = 1; rst_btn_n = 1; mrdy = 1; run = 1; step = 0;
    model_step(1, 1, 1, 0);
    @(posedge clk);
    @(negedge clk);

    repeat (3) tick("reset");
    drv_rst = 0;
    repeat (150) tick("hold_run");
    check("hold_pending", {15'd0, reset_b}, 16'd0);

    // Press long enough to be accepted during the hold: hold must restart.
    drv_btn = 0;
    repeat ($urandom_range(DEBOUNCE, DEBOUNCE + 12)) tick("press");
    drv_btn = 1;
    repeat (1000) tick("re_hold");
    check("hold_done", {15'd0, reset_b}, 16'd1);

    // A bounce shorter than the debounce window must not reset the CPU.
    drv_btn = 0;
    repeat (DEBOUNCE - 3) tick("bounce");
    drv_btn = 1;
    repeat (40) tick("bounce_after");
    check("bounce_no_reset", {15'd0, reset_b}, 16'd1);

    // Synchronous reset in the middle of a stretch.
    guard = 0;
    while ((m_cnt - m_base < 4 * QTR_DIV + 1) && guard < 2000) begin
      tick("seek_stretch");
      guard++;
    end
    check("stretch_found", {15'd0, stretching}, 16'd1);
    drv_rst = 1;
    tick("mid_rst");
    drv_rst = 0;
    check("mid_rst_zero", {10'd0, e, q, e_rise, e_fall, stretching, reset_b}, 16'd0);
    repeat (120) tick("post_rst");

`ifdef M6809_CLK_STEP_EN
    drv_run = 0;
    repeat (80) tick("park");
    check("parked", {14'd0, e, q}, 16'd0);
    rises = 0;
    falls = 0;
    drv_step = 1;
    tick("step");
    drv_step = 0;
    for (int i = 0; i < 8; i++) begin
      tick("step_run");
      rises += int'(e_rise);
      falls += int'(e_fall);
    end
    drv_step = 1;
    tick("step_ignored");
    drv_step = 0;
    for (int i = 0; i < 70; i++) begin
      tick("step_run2");
      rises += int'(e_rise);
      falls += int'(e_fall);
    end
    check("step_one_rise", 16'(rises), 16'd1);
    check("step_one_fall", 16'(falls), 16'd1);
    check("reparked", {14'd0, e, q}, 16'd0);
    drv_run = 1;
    repeat (60) tick("resume");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
